// File: rtl/q_pipe_sequencer_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// q_pipe_sequencer_if
// Bundles the signals between the clocked sequencer and a chain of self-timed
// q_stage cells.
//   q_start  sequencer -> chain   start of every stage
//   q_rst    sequencer -> chain   rst of every stage
//   q_pi     sequencer -> chain   head request (pi of first stage)
//   q_po     chain -> sequencer   head acknowledge (po of first stage), async
//   q_so     chain -> sequencer   tail request (so of last stage), async
//   q_si     sequencer -> chain   tail acknowledge (si of last stage)
//   q_f      chain -> sequencer   per-stage fault flags, async
// Modports: master = sequencer side, slave = chain side.
// ----------------------------------------------------------------------------
interface q_pipe_sequencer_if #(
    parameter int NSTAGES = 2
);
    logic               q_start;
    logic               q_rst;
    logic               q_pi;
    logic               q_po;
    logic               q_so;
    logic               q_si;
    logic [NSTAGES-1:0] q_f;

    modport master (
        output q_start, q_rst, q_pi, q_si,
        input  q_po, q_so, q_f
    );

    modport slave (
        input  q_start, q_rst, q_pi, q_si,
        output q_po, q_so, q_f
    );
endinterface

// File: rtl/q_pipe_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// q_pipe_sequencer
// Clocked sequencer for a linear chain of self-timed q_stage cells. Runs the
// start/rst bring-up sequence, injects n_tokens tokens at the chain head with a
// 4-phase handshake, drains them at the tail, and flags stalls or stage faults.
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   go              1-clk pulse: latch n_tokens and start (IDLE/DONE/ERR only)
//   abort           return to IDLE next clock from any state
//   n_tokens        number of tokens to inject
//   bus (master)    q_start/q_rst/q_pi/q_si out, q_po/q_so/q_f in
//   busy            high in RSTA/RSTB/RUN/DRAIN
//   done            1-clk pulse on successful completion
//   err             high while parked in ERR (stall watchdog or stage fault)
//   tok_in/tok_out  tokens accepted at the head / drained at the tail
// ----------------------------------------------------------------------------
module q_pipe_sequencer #(
    parameter int NSTAGES     = 2,
    parameter int CNT_W       = 8,
    parameter int RST_CYCLES  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     n_tokens,
    q_pipe_sequencer_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     tok_in,
    output logic [CNT_W-1:0]     tok_out
);
    localparam int PH_W = $clog2(((RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES) + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] MAX_INFLIGHT = CNT_W'(NSTAGES);
    localparam logic [PH_W-1:0]  PH_A_LAST    = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_B_LAST    = PH_W'(HOLD_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RSTA, S_RSTB, S_RUN, S_DRAIN, S_DONE, S_ERR
    } state_e;

    typedef enum logic [1:0] {
        H_IDLE, H_UP, H_DN
    } head_e;

    state_e             state_q, state_d;
    head_e              head_q, head_d, head_n;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   tok_in_q, tok_in_d, tin_n;
    logic [CNT_W-1:0]   tok_out_q, tok_out_d, tout_n;
    logic               q_pi_q, q_pi_d, pi_n;
    logic               q_si_q, q_si_d, si_n;
    logic               q_start_q, q_rst_q, busy_q, done_q, err_q;

    // Two-flop synchronizers; *_prev_q holds the previous synced value so the
    // watchdog can see input edges.
    logic               po_meta_q, po_s_q, po_prev_q;
    logic               so_meta_q, so_s_q, so_prev_q;
    logic [NSTAGES-1:0] f_meta_q, f_s_q;

    logic active;
    logic wd_clr;
    logic wd_expire;

    assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

    // Head and tail handshake next values, valid only while active. Kept apart
    // from the main FSM so the watchdog can look at them without a loop.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        head_n = head_q;
        pi_n   = q_pi_q;
        si_n   = q_si_q;
        tin_n  = tok_in_q;
        tout_n = tok_out_q;
        if (state_q == S_RUN) begin
            case (head_q)
                H_IDLE: begin
                    if (((tok_in_q - tok_out_q) < MAX_INFLIGHT) && (tok_in_q < n_q)) begin
                        pi_n   = 1'b1;
                        head_n = H_UP;
                    end
                end
                H_UP: begin
                    if (po_s_q) begin
                        pi_n   = 1'b0;
                        head_n = H_DN;
                    end
                end
                H_DN: begin
                    if (!po_s_q) begin
                        tin_n  = tok_in_q + 1'b1;
                        head_n = H_IDLE;
                    end
                end
                default: head_n = H_IDLE;
            endcase
        end
        if (active) begin
            if (so_s_q && !q_si_q) begin
                si_n = 1'b1;
            end else if (!so_s_q && q_si_q) begin
                si_n   = 1'b0;
                tout_n = tok_out_q + 1'b1;
            end
        end
    end

    // Any handshake edge, in either direction, proves the chain is alive.
    assign wd_clr    = (pi_n != q_pi_q) || (si_n != q_si_q) ||
                       (po_s_q != po_prev_q) || (so_s_q != so_prev_q);
    assign wd_d      = (active && !wd_clr) ? wd_q + 1'b1 : '0;
    assign wd_expire = active && !wd_clr && (wd_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        ph_d      = ph_q;
        n_d       = n_q;
        tok_in_d  = tok_in_q;
        tok_out_d = tok_out_q;
        q_pi_d    = q_pi_q;
        q_si_d    = q_si_q;
        if (abort) begin
            state_d = S_IDLE;
            head_d  = H_IDLE;
            ph_d    = '0;
            q_pi_d  = 1'b0;
            q_si_d  = 1'b0;
        end else if ((active && (|f_s_q)) || wd_expire) begin
            // Counters are left frozen so software can read where it stopped.
            state_d = S_ERR;
            head_d  = H_IDLE;
            q_pi_d  = 1'b0;
            q_si_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        state_d   = S_RSTA;
                        head_d    = H_IDLE;
                        ph_d      = '0;
                        n_d       = n_tokens;
                        tok_in_d  = '0;
                        tok_out_d = '0;
                    end
                end
                S_RSTA: begin
                    if (ph_q == PH_A_LAST) begin
                        ph_d    = '0;
                        state_d = S_RSTB;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                S_RSTB: begin
                    if (ph_q == PH_B_LAST) begin
                        ph_d    = '0;
                        head_d  = H_IDLE;
                        state_d = (n_q == '0) ? S_DONE : S_RUN;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                S_RUN: begin
                    head_d    = head_n;
                    q_pi_d    = pi_n;
                    q_si_d    = si_n;
                    tok_in_d  = tin_n;
                    tok_out_d = tout_n;
                    if ((head_q == H_IDLE) && (tok_in_q == n_q)) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    q_si_d    = si_n;
                    tok_out_d = tout_n;
                    if (tok_out_q == n_q) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: synchronous reset inside the clocked block; sequential state uses
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            head_q    <= H_IDLE;
            ph_q      <= '0;
            wd_q      <= '0;
            n_q       <= '0;
            tok_in_q  <= '0;
            tok_out_q <= '0;
            q_pi_q    <= 1'b0;
            q_si_q    <= 1'b0;
            q_start_q <= 1'b0;
            q_rst_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            po_meta_q <= 1'b0;
            po_s_q    <= 1'b0;
            po_prev_q <= 1'b0;
            so_meta_q <= 1'b0;
            so_s_q    <= 1'b0;
            so_prev_q <= 1'b0;
            f_meta_q  <= '0;
            f_s_q     <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            ph_q      <= ph_d;
            wd_q      <= wd_d;
            n_q       <= n_d;
            tok_in_q  <= tok_in_d;
            tok_out_q <= tok_out_d;
            q_pi_q    <= q_pi_d;
            q_si_q    <= q_si_d;
            // Stage controls and status are registered from the next state so
            // the chain never sees combinational glitches.
            q_start_q <= (state_d == S_RSTA);
            q_rst_q   <= !((state_d == S_RUN) || (state_d == S_DRAIN));
            busy_q    <= (state_d == S_RSTA) || (state_d == S_RSTB) ||
                         (state_d == S_RUN)  || (state_d == S_DRAIN);
            done_q    <= (state_d == S_DONE) && (state_q != S_DONE);
            err_q     <= (state_d == S_ERR);
            po_meta_q <= bus.q_po;
            po_s_q    <= po_meta_q;
            po_prev_q <= po_s_q;
            so_meta_q <= bus.q_so;
            so_s_q    <= so_meta_q;
            so_prev_q <= so_s_q;
            f_meta_q  <= bus.q_f;
            f_s_q     <= f_meta_q;
        end
    end

    assign bus.q_start = q_start_q;
    assign bus.q_rst   = q_rst_q;
    assign bus.q_pi    = q_pi_q;
    assign bus.q_si    = q_si_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign tok_in      = tok_in_q;
    assign tok_out     = tok_out_q;
endmodule

// File: tb/tb_q_pipe_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_q_pipe_sequencer
// Self-checking bench: cycle table for the bring-up sequence plus directed
// sequences against a behavioural two-stage chain model.
// ----------------------------------------------------------------------------
module tb_q_pipe_sequencer;
    localparam int NST = 2;
    localparam int CW  = 8;
    localparam int TO  = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic          abort;
    logic [CW-1:0] n_tokens;
    logic          busy, done, err;
    logic [CW-1:0] tok_in, tok_out;

    q_pipe_sequencer_if #(.NSTAGES(NST)) bus ();

    q_pipe_sequencer #(
        .NSTAGES(NST), .CNT_W(CW), .RST_CYCLES(4), .HOLD_CYCLES(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .n_tokens(n_tokens),
        .bus(bus), .busy(busy), .done(done), .err(err),
        .tok_in(tok_in), .tok_out(tok_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Chain model controls (written only by the main test process)
    logic model_en = 1'b0;
    int   stuck_at = 32'h7fffffff;
    // Chain model token counts (each written only by its own process)
    int   head_tok = 0;
    int   tail_tok = 0;

    // Monitor results (written only by the monitor)
    int   cyc = 0, done_cnt = 0, occ_viol = 0, last_edge = 0, err_delta = -1;

    typedef struct {
        logic          go;
        logic          abort;
        logic [CW-1:0] n;
        logic [6:0]    exp;   // {q_start, q_rst, q_pi, q_si, busy, done, err}
    } vec_t;

    vec_t vecs[16];

    function automatic logic [6:0] outs();
        return {bus.q_start, bus.q_rst, bus.q_pi, bus.q_si, busy, done, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_go(input logic [CW-1:0] n);
        @(negedge clk);
        go = 1'b1;
        n_tokens = n;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic model_flush();
        model_en = 1'b0;
        stuck_at = 32'h7fffffff;
        repeat (10) @(negedge clk);
    endtask

    // Head of the chain: acknowledges each request after a 5-10 ns delay.
    initial begin : head_model
        int unsigned d;
        bus.q_po = 1'b0;
        forever begin
            @(negedge clk);
            if (!model_en) begin
                bus.q_po = 1'b0;
            end else if (bus.q_pi && (head_tok < stuck_at)) begin
                d = $urandom_range(10, 5);
                #(d);
                bus.q_po = 1'b1;
                wait (!bus.q_pi || !model_en);
                d = $urandom_range(10, 5);
                #(d);
                bus.q_po = 1'b0;
                head_tok++;
            end
        end
    end

    // Tail of the chain: presents every accepted token back to the sequencer.
    initial begin : tail_model
        int unsigned d;
        bus.q_so = 1'b0;
        forever begin
            @(negedge clk);
            if (!model_en) begin
                bus.q_so = 1'b0;
                tail_tok = head_tok;
            end else if (head_tok != tail_tok) begin
                d = $urandom_range(10, 5);
                #(d);
                bus.q_so = 1'b1;
                wait (bus.q_si || !model_en);
                d = $urandom_range(10, 5);
                #(d);
                bus.q_so = 1'b0;
                wait (!bus.q_si || !model_en);
                tail_tok++;
            end
        end
    end

    initial begin : monitor
        logic p_pi, p_si, p_po, p_so, p_err;
        int   occ;
        {p_pi, p_si, p_po, p_so, p_err} = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) done_cnt++;
            occ = int'(tok_in) - int'(tok_out);
            if (occ > NST || occ < 0) occ_viol++;
            if (err === 1'b1 && p_err !== 1'b1) err_delta = cyc - last_edge;
            if (bus.q_pi !== p_pi || bus.q_si !== p_si || bus.q_po !== p_po || bus.q_so !== p_so)
                last_edge = cyc;
            {p_pi, p_si, p_po, p_so, p_err} = {bus.q_pi, bus.q_si, bus.q_po, bus.q_so, err};
        end
    end

    initial begin : guard
        #500us;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int dsnap, vsnap, lat, k;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; n_tokens = '0;
        bus.q_f = '0;

        // Bring-up sequence with n_tokens=0, go ignored while busy, abort priority.
        vecs[0]  = '{1'b1, 1'b0, 8'd0, 7'b1100100};
        vecs[1]  = '{1'b0, 1'b0, 8'd0, 7'b1100100};
        vecs[2]  = '{1'b1, 1'b0, 8'd9, 7'b1100100};
        vecs[3]  = '{1'b0, 1'b0, 8'd0, 7'b1100100};
        vecs[4]  = '{1'b0, 1'b0, 8'd0, 7'b0100100};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 7'b0100100};
        vecs[6]  = '{1'b0, 1'b0, 8'd0, 7'b0100100};
        vecs[7]  = '{1'b0, 1'b0, 8'd0, 7'b0100100};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 7'b0100010};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 7'b0100000};
        vecs[10] = '{1'b1, 1'b0, 8'd0, 7'b1100100};
        vecs[11] = '{1'b0, 1'b1, 8'd0, 7'b0100000};
        vecs[12] = '{1'b1, 1'b1, 8'd0, 7'b0100000};
        vecs[13] = '{1'b0, 1'b0, 8'd0, 7'b0100000};
        vecs[14] = '{1'b1, 1'b0, 8'd0, 7'b1100100};
        vecs[15] = '{1'b0, 1'b0, 8'd0, 7'b1100100};

        // 1) reset, then idle with no go
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle_after_reset[%0d]", i), {outs(), tok_in, tok_out}, {7'b0100000, 16'd0});
        end

        // 2) table: go with n_tokens=0 and control corner cases
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            go = vecs[i].go; abort = vecs[i].abort; n_tokens = vecs[i].n;
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i), {outs(), tok_in}, {vecs[i].exp, 8'd0});
        end
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        pulse_abort();

        // 3) five tokens through the behavioural chain
        model_en = 1'b1;
        dsnap = done_cnt; vsnap = occ_viol;
        pulse_go(8'd5);
        for (k = 0; k < 3000 && done_cnt == dsnap; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t3_done_once", done_cnt - dsnap, 1);
        check("t3_tok_in", tok_in, 5);
        check("t3_tok_out", tok_out, 5);
        check("t3_err", err, 0);
        check("t3_busy", busy, 0);
        check("t3_occupancy_viol", occ_viol - vsnap, 0);
        model_flush();

        // 4) head acknowledge stuck low after the first token
        stuck_at = head_tok + 1;
        model_en = 1'b1;
        pulse_go(8'd3);
        for (k = 0; k < 800 && !err; k++) @(negedge clk);
        @(negedge clk);
        check("t4_err_set", err, 1);
        check_rng("t4_wd_latency", err_delta, TO - 1, TO + 5);
        check("t4_tok_in", tok_in, 1);
        check("t4_pi_si_rst_busy", {bus.q_pi, bus.q_si, bus.q_rst, busy}, 4'b0010);
        model_flush();
        check("t4_err_sticky", err, 1);

        // 5) stage fault mid-RUN, then restart from ERR
        model_en = 1'b1;
        pulse_go(8'd5);
        for (k = 0; k < 1000 && tok_in < 2; k++) @(negedge clk);
        check("t5_reached_two_tokens", tok_in >= 2, 1);
        bus.q_f = 2'b10;
        lat = 0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) bus.q_f = '0;
            if (err) lat = i;
        end
        check_rng("t5_fault_latency", lat, 1, 3);
        model_flush();
        dsnap = done_cnt;
        @(negedge clk);
        go = 1'b1; n_tokens = 8'd0;
        @(posedge clk);
        #1;
        check("t5_restart_rsta", {err, bus.q_start, busy}, 3'b011);
        @(negedge clk);
        go = 1'b0;
        for (k = 0; k < 30 && done_cnt == dsnap; k++) @(negedge clk);
        check("t5_restart_done", done_cnt - dsnap, 1);

        // 6) abort during H_UP, go ignored in RUN, reset mid-RSTB
        pulse_go(8'd3);
        for (k = 0; k < 40 && !bus.q_pi; k++) @(negedge clk);
        check("t6_in_h_up", bus.q_pi, 1);
        pulse_abort();
        check("t6_abort_idle", {outs(), tok_in}, {7'b0100000, 8'd0});
        pulse_go(8'd3);
        for (k = 0; k < 40 && bus.q_rst; k++) @(negedge clk);
        check("t6_in_run", {bus.q_rst, busy}, 2'b01);
        pulse_go(8'd7);
        check("t6_go_ignored", {bus.q_start, bus.q_rst, busy, bus.q_pi}, 4'b0011);
        pulse_abort();
        pulse_go(8'd3);
        repeat (5) @(negedge clk);
        check("t6_in_rstb", {bus.q_start, bus.q_rst, busy}, 3'b011);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_reset_idle", {outs(), tok_in, tok_out}, {7'b0100000, 16'd0});
        repeat (3) @(negedge clk);
        check("t6_stays_idle", {outs(), busy}, {7'b0100000, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
